// File: rtl/data_bus_responder.sv
// Data-port responder for the rv32i core: word RAM plus LED, key-event FIFO
// and cycle-counter registers. Load data is combinational from addr and state.
module data_bus_responder #(
    parameter int unsigned RAM_DEPTH = 1024,
    parameter int unsigned KEY_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_w,
    input  logic        mem_r,
    output logic [31:0] rdata,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    output logic [15:0] leds,
    output logic        key_irq
);

    localparam int unsigned RAW = $clog2(RAM_DEPTH);
    localparam int unsigned KPW = $clog2(KEY_DEPTH);
    localparam int unsigned KCW = KPW + 1;

    localparam logic [29:0]    LED_WA   = MMIO_BASE[31:2];
    localparam logic [29:0]    STAT_WA  = MMIO_BASE[31:2] + 30'd1;
    localparam logic [29:0]    KDAT_WA  = MMIO_BASE[31:2] + 30'd2;
    localparam logic [29:0]    CYC_WA   = MMIO_BASE[31:2] + 30'd3;
    localparam logic [KCW-1:0] KEY_FULL = KCW'(KEY_DEPTH);

    logic [31:0]    ram_q [RAM_DEPTH];
    logic [7:0]     key_mem_q [KEY_DEPTH];
    logic [7:0]     key_mem_d [KEY_DEPTH];
    logic [KPW-1:0] wr_ptr_q, wr_ptr_d;
    logic [KPW-1:0] rd_ptr_q, rd_ptr_d;
    logic [KCW-1:0] count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    led_q, led_d;
    logic [31:0]    cycle_q, cycle_d;
    logic           key_irq_q, key_irq_d;

    logic [29:0]    word_addr_s;
    logic [RAW-1:0] ram_idx_s;
    logic           is_ram_s;
    logic           pop_s;
    logic           push_ok_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic [31:0]    status_s;
    logic           unused_addr_s;

    assign word_addr_s   = addr[31:2];
    assign ram_idx_s     = addr[RAW+1:2];
    assign is_ram_s      = (word_addr_s < 30'(RAM_DEPTH));
    assign unused_addr_s = &{1'b0, addr[1:0]};
    assign fifo_full_s   = (count_q == KEY_FULL);
    assign fifo_empty_s  = (count_q == {KCW{1'b0}});

    // Pop needs a pure load of KEY_DATA; a push into a full FIFO is only taken if a pop frees a slot
    always_comb begin
        pop_s     = 1'b0;
        push_ok_s = 1'b0;
        if (mem_r && !mem_w && (word_addr_s == KDAT_WA) && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (key_valid && (!fifo_full_s || pop_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Next-state for registers, FIFO and counter
    always_comb begin
        key_mem_d  = key_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        led_d      = led_q;
        cycle_d    = cycle_q + 32'd1;

        if (mem_w && (word_addr_s == LED_WA)) begin
            led_d = wdata[15:0];
        end else begin
            led_d = led_q;
        end

        if (mem_w && (word_addr_s == CYC_WA)) begin
            cycle_d = wdata;
        end else begin
            cycle_d = cycle_q + 32'd1;
        end

        if (push_ok_s) begin
            key_mem_d[wr_ptr_q] = key_code;
            wr_ptr_d            = wr_ptr_q + KPW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + KPW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + KCW'(1);
            2'b01:   count_d = count_q - KCW'(1);
            default: count_d = count_q;
        endcase

        // Setting outranks a same-cycle software clear
        if (key_valid && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else if (mem_w && (word_addr_s == STAT_WA) && wdata[8]) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    assign key_irq_d = (count_d != {KCW{1'b0}});

    // Status word assembly
    always_comb begin
        status_s      = 32'd0;
        status_s[0]   = !fifo_empty_s;
        status_s[1]   = fifo_full_s;
        status_s[7:4] = 4'(count_q);
        status_s[8]   = overflow_q;
    end

    // Load data mux
    always_comb begin
        rdata = 32'd0;
        if (is_ram_s) begin
            rdata = ram_q[ram_idx_s];
        end else if (word_addr_s == LED_WA) begin
            rdata = {16'd0, led_q};
        end else if (word_addr_s == STAT_WA) begin
            rdata = status_s;
        end else if (word_addr_s == KDAT_WA) begin
            rdata = fifo_empty_s ? 32'd0 : {24'd0, key_mem_q[rd_ptr_q]};
        end else if (word_addr_s == CYC_WA) begin
            rdata = cycle_q;
        end else begin
            rdata = 32'd0;
        end
    end

    // RAM array: contents are not reset
    always_ff @(posedge clk) begin
        if (mem_w && is_ram_s) begin
            ram_q[ram_idx_s] <= wdata;
        end
    end

    // Peripheral and FIFO state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(KEY_DEPTH); i++) begin
                key_mem_q[i] <= 8'd0;
            end
            wr_ptr_q   <= {KPW{1'b0}};
            rd_ptr_q   <= {KPW{1'b0}};
            count_q    <= {KCW{1'b0}};
            overflow_q <= 1'b0;
            led_q      <= 16'd0;
            cycle_q    <= 32'd0;
            key_irq_q  <= 1'b0;
        end else begin
            key_mem_q  <= key_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            led_q      <= led_d;
            cycle_q    <= cycle_d;
            key_irq_q  <= key_irq_d;
        end
    end

    assign leds    = led_q;
    assign key_irq = key_irq_q;

endmodule
